// File: rtl/trig_lut_seq.sv
// trig_lut_seq: sequential sine/cosine lookup for the cube-rotation datapath.
// Latches CHANNELS angles (whole degrees), issues one channel per cycle into a
// 3-stage pipeline (mod 360 -> quadrant fold -> quarter-table read + negate) and
// returns signed results scaled to +/-100 with a one-cycle done pulse.
// Optional feature macro: TRIG_COS_EN (cos path present when defined; otherwise
// cos_out is tied to zero).
module trig_lut_seq #(
  parameter int CHANNELS = 3,
  parameter int ANGLE_W  = 10,
  parameter int OUT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [CHANNELS*ANGLE_W-1:0] angle_in,
  output logic                        busy,
  output logic                        done,
  output logic [CHANNELS*OUT_W-1:0]   sin_out,
  output logic [CHANNELS*OUT_W-1:0]   cos_out
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [CHANNELS*ANGLE_W-1:0] angles_q, angles_d;
  logic                        issue_q, issue_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        s1_v_q, s1_v_d;
  logic [CW-1:0]               s1_ch_q, s1_ch_d;
  logic [8:0]                  s1_a_q, s1_a_d;
  logic                        s2_v_q, s2_v_d;
  logic [CW-1:0]               s2_ch_q, s2_ch_d;
  logic [6:0]                  s2_sidx_q, s2_sidx_d;
  logic                        s2_sneg_q, s2_sneg_d;
  logic                        done_q, done_d;
  logic [CHANNELS*OUT_W-1:0]   sin_q, sin_d;
  logic [ANGLE_W-1:0]          ang_sel_s;
`ifdef TRIG_COS_EN
  logic [6:0]                  s2_cidx_q, s2_cidx_d;
  logic                        s2_cneg_q, s2_cneg_d;
  logic [CHANNELS*OUT_W-1:0]   cos_q, cos_d;
`endif

  // Reduce any ANGLE_W-bit angle (<= 4095) modulo 360 by restoring subtraction.
  function automatic logic [8:0] mod360(input logic [ANGLE_W-1:0] ang);
    logic [12:0] x;
    x = 13'(ang);
    if (x >= 13'd2880) x = x - 13'd2880; else x = x;
    if (x >= 13'd1440) x = x - 13'd1440; else x = x;
    if (x >= 13'd720)  x = x - 13'd720;  else x = x;
    if (x >= 13'd360)  x = x - 13'd360;  else x = x;
    return x[8:0];
  endfunction

  // Fold a reduced angle onto the quarter table: {negate, index}.
  function automatic logic [7:0] fold(input logic [8:0] a);
    logic [7:0] r;
    if (a <= 9'd90)       r = {1'b0, 7'(a)};
    else if (a <= 9'd180) r = {1'b0, 7'(9'd180 - a)};
    else if (a <= 9'd270) r = {1'b1, 7'(a - 9'd180)};
    else                  r = {1'b1, 7'(9'd360 - a)};
    return r;
  endfunction

  // Quarter-wave table: round(100*sin(k deg)), half away from zero.
  function automatic logic [6:0] tbl(input logic [6:0] k);
    logic [6:0] t;
    case (k)
      7'd0: t = 7'd0;   7'd1: t = 7'd2;   7'd2: t = 7'd3;   7'd3: t = 7'd5;   7'd4: t = 7'd7;   7'd5: t = 7'd9;
      7'd6: t = 7'd10;  7'd7: t = 7'd12;  7'd8: t = 7'd14;  7'd9: t = 7'd16;  7'd10: t = 7'd17; 7'd11: t = 7'd19;
      7'd12: t = 7'd21; 7'd13: t = 7'd22; 7'd14: t = 7'd24; 7'd15: t = 7'd26; 7'd16: t = 7'd28; 7'd17: t = 7'd29;
      7'd18: t = 7'd31; 7'd19: t = 7'd33; 7'd20: t = 7'd34; 7'd21: t = 7'd36; 7'd22: t = 7'd37; 7'd23: t = 7'd39;
      7'd24: t = 7'd41; 7'd25: t = 7'd42; 7'd26: t = 7'd44; 7'd27: t = 7'd45; 7'd28: t = 7'd47; 7'd29: t = 7'd48;
      7'd30: t = 7'd50; 7'd31: t = 7'd52; 7'd32: t = 7'd53; 7'd33: t = 7'd54; 7'd34: t = 7'd56; 7'd35: t = 7'd57;
      7'd36: t = 7'd59; 7'd37: t = 7'd60; 7'd38: t = 7'd62; 7'd39: t = 7'd63; 7'd40: t = 7'd64; 7'd41: t = 7'd66;
      7'd42: t = 7'd67; 7'd43: t = 7'd68; 7'd44: t = 7'd69; 7'd45: t = 7'd71; 7'd46: t = 7'd72; 7'd47: t = 7'd73;
      7'd48: t = 7'd74; 7'd49: t = 7'd75; 7'd50: t = 7'd77; 7'd51: t = 7'd78; 7'd52: t = 7'd79; 7'd53: t = 7'd80;
      7'd54: t = 7'd81; 7'd55: t = 7'd82; 7'd56: t = 7'd83; 7'd57: t = 7'd84; 7'd58: t = 7'd85; 7'd59: t = 7'd86;
      7'd60: t = 7'd87; 7'd61: t = 7'd87; 7'd62: t = 7'd88; 7'd63: t = 7'd89; 7'd64: t = 7'd90; 7'd65: t = 7'd91;
      7'd66: t = 7'd91; 7'd67: t = 7'd92; 7'd68: t = 7'd93; 7'd69: t = 7'd93; 7'd70: t = 7'd94; 7'd71: t = 7'd95;
      7'd72: t = 7'd95; 7'd73: t = 7'd96; 7'd74: t = 7'd96; 7'd75: t = 7'd97; 7'd76: t = 7'd97; 7'd77: t = 7'd97;
      7'd78: t = 7'd98; 7'd79: t = 7'd98; 7'd80: t = 7'd98; 7'd81: t = 7'd99; 7'd82: t = 7'd99; 7'd83: t = 7'd99;
      7'd84: t = 7'd99; 7'd85: t = 7'd100; 7'd86: t = 7'd100; 7'd87: t = 7'd100; 7'd88: t = 7'd100;
      7'd89: t = 7'd100; 7'd90: t = 7'd100;
      default: t = 7'd0;
    endcase
    return t;
  endfunction

  // Table read plus optional two's-complement negation (negating 0 yields 0).
  function automatic logic [OUT_W-1:0] signed_val(input logic [6:0] idx, input logic neg);
    logic [OUT_W-1:0] m;
    m = OUT_W'(tbl(idx));
    return neg ? (~m + 1'b1) : m;
  endfunction

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      angles_q  <= '0;
      issue_q   <= 1'b0;
      cnt_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_ch_q   <= '0;
      s1_a_q    <= 9'd0;
      s2_v_q    <= 1'b0;
      s2_ch_q   <= '0;
      s2_sidx_q <= 7'd0;
      s2_sneg_q <= 1'b0;
      done_q    <= 1'b0;
      sin_q     <= '0;
`ifdef TRIG_COS_EN
      s2_cidx_q <= 7'd0;
      s2_cneg_q <= 1'b0;
      cos_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      angles_q  <= angles_d;
      issue_q   <= issue_d;
      cnt_q     <= cnt_d;
      s1_v_q    <= s1_v_d;
      s1_ch_q   <= s1_ch_d;
      s1_a_q    <= s1_a_d;
      s2_v_q    <= s2_v_d;
      s2_ch_q   <= s2_ch_d;
      s2_sidx_q <= s2_sidx_d;
      s2_sneg_q <= s2_sneg_d;
      done_q    <= done_d;
      sin_q     <= sin_d;
`ifdef TRIG_COS_EN
      s2_cidx_q <= s2_cidx_d;
      s2_cneg_q <= s2_cneg_d;
      cos_q     <= cos_d;
`endif
    end
  end

  // Next-state: accept, issue counter, three pipeline stages and done/idle return.
  always_comb begin
    state_d  = state_q;
    angles_d = angles_q;
    issue_d  = issue_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    sin_d    = sin_q;
    ang_sel_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ang_sel_s = (cnt_q == CW'(i)) ? angles_q[i*ANGLE_W +: ANGLE_W] : ang_sel_s;
    end
    // Stage 1: reduce the issued channel's angle.
    s1_v_d  = issue_q;
    s1_ch_d = cnt_q;
    s1_a_d  = mod360(ang_sel_s);
    // Stage 2: fold onto the quarter table.
    s2_v_d  = s1_v_q;
    s2_ch_d = s1_ch_q;
    {s2_sneg_d, s2_sidx_d} = fold(s1_a_q);
`ifdef TRIG_COS_EN
    cos_d = cos_q;
    if ((10'(s1_a_q) + 10'd90) >= 10'd360) begin
      {s2_cneg_d, s2_cidx_d} = fold(9'(10'(s1_a_q) + 10'd90 - 10'd360));
    end else begin
      {s2_cneg_d, s2_cidx_d} = fold(9'(10'(s1_a_q) + 10'd90));
    end
`endif
    // Stage 3: table read, negate, write the channel slot.
    for (int i = 0; i < CHANNELS; i++) begin
      if (s2_v_q && (s2_ch_q == CW'(i))) begin
        sin_d[i*OUT_W +: OUT_W] = signed_val(s2_sidx_q, s2_sneg_q);
`ifdef TRIG_COS_EN
        cos_d[i*OUT_W +: OUT_W] = signed_val(s2_cidx_q, s2_cneg_q);
`endif
      end else begin
        sin_d[i*OUT_W +: OUT_W] = sin_q[i*OUT_W +: OUT_W];
      end
    end
    // Issue one channel per cycle; stop after the last one.
    if (issue_q) begin
      if (cnt_q == CW'(CHANNELS - 1)) begin
        issue_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
    // Writing the last channel ends the request.
    if (s2_v_q && (s2_ch_q == CW'(CHANNELS - 1))) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else begin
      done_d  = 1'b0;
    end
    // Accept only while idle; busy requests ignore start.
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          angles_d = angle_in;
          issue_d  = 1'b1;
          cnt_d    = '0;
        end else begin
          state_d  = state_d;
        end
      end
      RUN:     state_d = state_d;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign sin_out = sin_q;
`ifdef TRIG_COS_EN
  assign cos_out = cos_q;
`else
  assign cos_out = '0;
`endif

endmodule
